instr_fetch_unit: RTL and testbench

Fetches instructions from instruction memory and hands them to the control unit over a valid/ready interface, one instruction per transfer.
- Owns the PC, issues word-aligned requests to instruction memory and buffers returned words with their PCs in a small FIFO.
- Accepts branch/jump redirects from the datapath, which flush the buffer and discard any in-flight response.

---
 rtl/fetch_pkg.sv | 8 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/instr_fetch_unit.sv | 73 +++++++
 tb/tb_instr_fetch_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch unit.
package fetch_pkg;
    typedef enum logic [1:0] {REQ, WAIT, DRAIN} fetch_state_t;
    localparam int INSTR_BYTES = 4;
    localparam int DEFAULT_AW = 32;
    localparam int DEFAULT_IW = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry buffer of fetched words and their PCs; flush beats push/pop.
module fetch_fifo #(
    parameter int IW = 32,
    parameter int AW = 32,
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [IW-1:0] push_instr_i,
    input  logic [AW-1:0] push_pc_i,
    output logic [IW-1:0] head_instr_o,
    output logic [AW-1:0] head_pc_o,
    output logic [CW-1:0] count_o
);
    logic [IW-1:0] instr_q [DEPTH];
    logic [AW-1:0] pc_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    assign head_instr_o = instr_q[rd_ptr_q];
    assign head_pc_o = pc_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                instr_q[wr_ptr_q] <= push_instr_i;
                pc_q[wr_ptr_q] <= push_pc_i;
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_i)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner issuing one outstanding imem request at a time,
// buffering responses for the control unit and discarding them after redirects.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int IW = DEFAULT_IW,
    parameter int DEPTH = 2,
    parameter logic [AW-1:0] RESET_PC = AW'(DEFAULT_RESET_PC)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic          imem_rvalid,
    input  logic [IW-1:0] imem_rdata,
    output logic          instr_valid,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    input  logic          instr_ready,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic [CW-1:0] count;
    logic accept, push, pop;

    // An outstanding request already owns a FIFO slot, so only REQ checks fullness.
    assign imem_req = !reset && state_q == REQ && count < CW'(DEPTH) && !redirect_valid;
    assign imem_addr = pc_q;
    assign accept = imem_req && imem_ready;
    assign push = state_q == WAIT && imem_rvalid && !redirect_valid;
    assign instr_valid = !reset && count != '0 && !redirect_valid;
    assign pop = instr_valid && instr_ready;

    always_comb begin
        state_d = state_q == REQ ? (accept ? WAIT : REQ)
                : imem_rvalid ? REQ
                : redirect_valid ? DRAIN : state_q;
        pc_d = redirect_valid ? (redirect_pc & ~AW'(3))
             : accept ? pc_q + AW'(INSTR_BYTES) : pc_q;
        req_pc_d = accept ? pc_q : req_pc_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= REQ;
            pc_q <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_fifo #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push_i(push),
        .pop_i(pop),
        .flush_i(redirect_valid),
        .push_instr_i(imem_rdata),
        .push_pc_i(req_pc_q),
        .head_instr_o(instr),
        .head_pc_o(instr_pc),
        .count_o(count)
    );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: cycle-by-cycle directed vectors plus wrap and async-reset sequences.
module tb_instr_fetch_unit;
    logic clk = 0, reset = 0;
    logic imem_ready = 0, imem_rvalid = 0, instr_ready = 0, redirect_valid = 0;
    logic [31:0] imem_rdata = 0, redirect_pc = 0;
    logic imem_req, instr_valid, w_req, w_valid;
    logic [31:0] imem_addr, instr, instr_pc, w_addr, w_instr, w_pc;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_pc),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    typedef struct {
        bit r; bit rdy; bit rv; logic [31:0] rd; bit ir; bit red; logic [31:0] rpc;
        bit er; logic [31:0] ea; bit eiv; logic [31:0] ei; logic [31:0] ep;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit r, bit rdy, bit rv, logic [31:0] rd, bit ir, bit red,
                               logic [31:0] rpc, bit er, logic [31:0] ea, bit eiv,
                               logic [31:0] ei, logic [31:0] ep);
        vec_t x;
        x.r = r; x.rdy = rdy; x.rv = rv; x.rd = rd; x.ir = ir; x.red = red; x.rpc = rpc;
        x.er = er; x.ea = ea; x.eiv = eiv; x.ei = ei; x.ep = ep;
        return x;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        {imem_ready, imem_rvalid, instr_ready, redirect_valid} = '0;
        imem_rdata = 0;
        redirect_pc = 0;
        reset = 1;
        #2 reset = 0;
    endtask

    task automatic drive(bit rdy, bit rv, logic [31:0] rd, bit ir, bit red, logic [31:0] rpc);
        @(negedge clk);
        imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
        instr_ready = ir; redirect_valid = red; redirect_pc = rpc;
        #1;
    endtask

    initial begin
        // test 1: streaming, one instruction every 2 cycles
        vecs.push_back(v(1,1,0,0,1,0,0, 1,32'h0,0,0,0));
        vecs.push_back(v(0,1,1,32'hD000_0000,1,0,0, 0,32'h4,0,0,0));
        vecs.push_back(v(0,1,0,0,1,0,0, 1,32'h4,1,32'hD000_0000,32'h0));
        vecs.push_back(v(0,1,1,32'hD111_1111,1,0,0, 0,32'h8,0,0,0));
        vecs.push_back(v(0,1,0,0,1,0,0, 1,32'h8,1,32'hD111_1111,32'h4));
        vecs.push_back(v(0,1,1,32'hD222_2222,1,0,0, 0,32'hC,0,0,0));
        vecs.push_back(v(0,1,0,0,1,0,0, 1,32'hC,1,32'hD222_2222,32'h8));
        // test 2: consumer stalled, buffer fills to DEPTH and fetch stops
        vecs.push_back(v(1,1,0,0,0,0,0, 1,32'h0,0,0,0));
        vecs.push_back(v(0,1,1,32'hA000_0000,0,0,0, 0,32'h4,0,0,0));
        vecs.push_back(v(0,1,0,0,0,0,0, 1,32'h4,1,32'hA000_0000,32'h0));
        vecs.push_back(v(0,1,1,32'hA111_1111,0,0,0, 0,32'h8,1,32'hA000_0000,32'h0));
        vecs.push_back(v(0,1,0,0,0,0,0, 0,32'h8,1,32'hA000_0000,32'h0));
        vecs.push_back(v(0,1,0,0,1,0,0, 0,32'h8,1,32'hA000_0000,32'h0));
        vecs.push_back(v(0,1,0,0,1,0,0, 1,32'h8,1,32'hA111_1111,32'h4));
        vecs.push_back(v(0,1,1,32'hA222_2222,1,0,0, 0,32'hC,0,0,0));
        vecs.push_back(v(0,1,0,0,1,0,0, 1,32'hC,1,32'hA222_2222,32'h8));
        // test 3: redirect while waiting, stale response drained
        vecs.push_back(v(1,1,0,0,1,0,0, 1,32'h0,0,0,0));
        vecs.push_back(v(0,1,1,32'hB000_0000,1,0,0, 0,32'h4,0,0,0));
        vecs.push_back(v(0,1,0,0,1,0,0, 1,32'h4,1,32'hB000_0000,32'h0));
        vecs.push_back(v(0,1,0,0,1,1,32'h103, 0,32'h8,0,0,0));
        vecs.push_back(v(0,1,0,0,1,0,0, 0,32'h100,0,0,0));
        vecs.push_back(v(0,1,1,32'hBAD0_BAD0,1,0,0, 0,32'h100,0,0,0));
        vecs.push_back(v(0,1,0,0,1,0,0, 1,32'h100,0,0,0));
        vecs.push_back(v(0,1,1,32'hB444_4444,1,0,0, 0,32'h104,0,0,0));
        vecs.push_back(v(0,1,0,0,1,0,0, 1,32'h104,1,32'hB444_4444,32'h100));
        // test 4: redirect coincides with rvalid and a ready consumer
        vecs.push_back(v(1,1,0,0,0,0,0, 1,32'h0,0,0,0));
        vecs.push_back(v(0,1,1,32'hC000_0000,0,0,0, 0,32'h4,0,0,0));
        vecs.push_back(v(0,1,0,0,0,0,0, 1,32'h4,1,32'hC000_0000,32'h0));
        vecs.push_back(v(0,1,1,32'hBAD1_BAD1,1,1,32'h200, 0,32'h8,0,0,0));
        vecs.push_back(v(0,1,0,0,1,0,0, 1,32'h200,0,0,0));
        vecs.push_back(v(0,1,1,32'hC555_5555,1,0,0, 0,32'h204,0,0,0));
        vecs.push_back(v(0,1,0,0,1,0,0, 1,32'h204,1,32'hC555_5555,32'h200));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].r) pulse_reset();
            drive(vecs[i].rdy, vecs[i].rv, vecs[i].rd, vecs[i].ir, vecs[i].red, vecs[i].rpc);
            check($sformatf("v%0d imem_req", i), 32'(imem_req), 32'(vecs[i].er));
            check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].ea);
            check($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].eiv));
            if (vecs[i].eiv) begin
                check($sformatf("v%0d instr", i), instr, vecs[i].ei);
                check($sformatf("v%0d instr_pc", i), instr_pc, vecs[i].ep);
            end
        end

        // test 5: PC wraps past the top of the address space
        pulse_reset();
        drive(1, 0, 0, 1, 0, 0);
        check("wrap req0", 32'(w_req), 1);
        check("wrap addr0", w_addr, 32'hFFFF_FFF8);
        drive(1, 1, 32'hE000_0000, 1, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        check("wrap addr1", w_addr, 32'hFFFF_FFFC);
        check("wrap pc0", w_pc, 32'hFFFF_FFF8);
        drive(1, 1, 32'hE111_1111, 1, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        check("wrap req2", 32'(w_req), 1);
        check("wrap addr2", w_addr, 32'h0);
        check("wrap pc1", w_pc, 32'hFFFF_FFFC);

        // test 6: asynchronous reset while WAIT with one buffered entry
        pulse_reset();
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 1, 32'hF000_0000, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        check("pre-reset valid", 32'(instr_valid), 1);
        check("pre-reset req", 32'(imem_req), 0);
        reset = 1;
        #1;
        check("async valid", 32'(instr_valid), 0);
        check("async req", 32'(imem_req), 0);
        check("async instr", instr, 0);
        check("async instr_pc", instr_pc, 0);
        check("async addr", imem_addr, 0);
        #1 reset = 0;
        #1;
        check("post-reset req", 32'(imem_req), 1);
        check("post-reset addr", imem_addr, 32'h0);
        check("post-reset valid", 32'(instr_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
